// File: rtl/div_issue_if.sv
// div_issue_if: EX/WB-side and divider-side signals of div_issue.
// slave modport is the div_issue view; master is the environment (pipeline + div unit) view.
interface div_issue_if;
  logic        flush;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic        wb_stall;
  logic        ex_stall;
  logic        mdu_done;
  logic [31:0] mdu_result;
  logic        div_valid;
  logic        div_stall;
  logic [2:0]  div_op;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_ready;
  logic [31:0] div_result;
  logic        div_err;
  modport slave (
    input  flush, ex_valid, ex_funct3, ex_rs1, ex_rs2, wb_stall, div_ready, div_result,
    output ex_stall, mdu_done, mdu_result, div_valid, div_stall, div_op, div_op1, div_op2, div_err
  );
  modport master (
    output flush, ex_valid, ex_funct3, ex_rs1, ex_rs2, wb_stall, div_ready, div_result,
    input  ex_stall, mdu_done, mdu_result, div_valid, div_stall, div_op, div_op1, div_op2, div_err
  );
endinterface

// File: rtl/div_issue.sv
// div_issue: EX-stage issue/control for RV32M divides in front of an iterative div unit.
// Ports: clk, rst (async, active-high); bus (div_issue_if.slave) carries the EX request
// (flush, ex_valid, ex_funct3, ex_rs1, ex_rs2), WB handshake (wb_stall, ex_stall, mdu_done,
// mdu_result), divider interface (div_valid, div_stall, div_op/op1/op2, div_ready, div_result)
// and the sticky watchdog flag div_err.
// Optional feature: DIV_RESULT_CACHE_EN adds a one-entry cache of the last divider result.
module div_issue #(
  parameter int WDOG_CYCLES = 48
) (
  input logic        clk,
  input logic        rst,
  div_issue_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_op1, r_op2, r_result, r_wdog;
  logic        r_err;
  logic        w_accept, w_div0, w_ovf, w_special, w_hit, w_busy, w_timeout;
  logic [31:0] w_special_res, w_hit_res;
  assign w_accept = r_state == IDLE && bus.ex_valid && bus.ex_funct3[2] && !bus.flush;
  assign w_div0 = bus.ex_rs2 == '0;
  // signed overflow only exists for DIV/REM (funct3[0]==0)
  assign w_ovf = !bus.ex_funct3[0] && bus.ex_rs1 == 32'h8000_0000 && bus.ex_rs2 == '1;
  assign w_special = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (bus.ex_funct3[1] ? bus.ex_rs1 : '1)
                                : (bus.ex_funct3[1] ? '0 : 32'h8000_0000);
  assign w_busy = r_state == WAIT || r_state == DRAIN;
  // a div_ready in the last allowed cycle still wins over the timeout
  assign w_timeout = WDOG_CYCLES != 0 && w_busy && !bus.div_ready && r_wdog == 32'(WDOG_CYCLES - 1);
`ifdef DIV_RESULT_CACHE_EN
  logic        r_c_valid;
  logic [2:0]  r_c_op;
  logic [31:0] r_c_op1, r_c_op2, r_c_res;
  assign w_hit = r_c_valid && r_c_op == bus.ex_funct3 && r_c_op1 == bus.ex_rs1 && r_c_op2 == bus.ex_rs2;
  assign w_hit_res = r_c_res;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_op    <= '0;
      r_c_op1   <= '0;
      r_c_op2   <= '0;
      r_c_res   <= '0;
    end else if (r_state == DRAIN || w_timeout) begin
      r_c_valid <= 1'b0;
    end else if (r_state == WAIT && bus.div_ready && !bus.flush) begin
      r_c_valid <= 1'b1;
      r_c_op    <= r_op;
      r_c_op1   <= r_op1;
      r_c_op2   <= r_op2;
      r_c_res   <= bus.div_result;
    end
`else
  assign w_hit = 1'b0;
  assign w_hit_res = '0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next         = r_state;
    bus.ex_stall   = 1'b0;
    bus.div_valid  = 1'b0;
    bus.div_stall  = 1'b0;
    bus.mdu_done   = 1'b0;
    bus.mdu_result = '0;
    case (r_state)
      IDLE: begin
        bus.ex_stall = w_accept;
        if (w_accept) w_next = (w_special || w_hit) ? DONE : ISSUE;
      end
      ISSUE: begin
        bus.ex_stall  = 1'b1;
        bus.div_valid = 1'b1;
        w_next        = bus.flush ? DRAIN : WAIT;
      end
      WAIT: begin
        bus.ex_stall  = 1'b1;
        bus.div_stall = bus.wb_stall;
        // a result arriving with flush is simply dropped; nothing left to drain
        w_next = bus.div_ready ? (bus.flush ? IDLE : DONE)
               : bus.flush ? DRAIN : w_timeout ? IDLE : WAIT;
      end
      DONE: begin
        bus.mdu_done   = !bus.flush;
        bus.mdu_result = r_result;
        bus.ex_stall   = bus.wb_stall;
        if (!bus.wb_stall || bus.flush) w_next = IDLE;
      end
      DRAIN: begin
        bus.ex_stall = 1'b1;
        if (bus.div_ready || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_op     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_wdog   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= bus.ex_funct3;
        r_op1 <= bus.ex_rs1;
        r_op2 <= bus.ex_rs2;
      end
      if (w_accept && w_special)                   r_result <= w_special_res;
      else if (w_accept && w_hit)                  r_result <= w_hit_res;
      else if (r_state == WAIT && bus.div_ready)   r_result <= bus.div_result;
      r_wdog <= r_state == ISSUE ? '0 : w_busy ? r_wdog + 32'd1 : r_wdog;
      if (w_timeout) r_err <= 1'b1;
    end
  assign bus.div_op  = r_op;
  assign bus.div_op1 = r_op1;
  assign bus.div_op2 = r_op2;
  assign bus.div_err = r_err;
endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: randomized self-checking bench for div_issue with a behavioural div unit.
module tb_div_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  div_issue_if bus ();
  div_issue #(.WDOG_CYCLES(48)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  bit mute = 1'b0;
  int force_lat = 0;
  bit c_valid = 1'b0;
  logic [2:0]  c_f;
  logic [31:0] c_a, c_b;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (f inside {3'd4, 3'd6} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return (f == 3'd6 || f == 3'd7) ? a : 32'hFFFF_FFFF;
    if (is_special(f, a, b)) return f == 3'd6 ? 32'd0 : 32'h8000_0000;
    case (f)
      3'd4:    return sa / sb;
      3'd5:    return a / b;
      3'd6:    return sa % sb;
      default: return a % b;
    endcase
  endfunction
  function automatic bit cache_hit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_RESULT_CACHE_EN
    return c_valid && c_f == f && c_a == a && c_b == b;
`else
    return 1'b0;
`endif
  endfunction
  initial begin : div_model
    bit busy = 1'b0;
    bit stable = 1'b1;
    int lat = 0;
    logic [2:0] op;
    logic [31:0] a, b;
    bus.div_ready = 1'b0;
    bus.div_result = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        busy = 1'b0;
        bus.div_ready = 1'b0;
      end else begin
        #1;
        bus.div_ready = 1'b0;
        if (bus.div_valid) begin
          n_valid++;
          if (!mute) begin
            busy = 1'b1;
            stable = 1'b1;
            op = bus.div_op;
            a = bus.div_op1;
            b = bus.div_op2;
            lat = force_lat != 0 ? force_lat : int'($urandom_range(2, 20));
          end
        end else if (busy) begin
          stable &= bus.div_op == op && bus.div_op1 == a && bus.div_op2 == b;
          lat--;
          if (lat == 0) begin
            bus.div_ready = 1'b1;
            bus.div_result = ref_res(op, a, b);
            busy = 1'b0;
            chk("div_operands_held", stable, 1);
          end
        end
      end
    end
  end
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    int v0 = n_valid;
    int cyc = 1;
    bit stall_ok = 1'b1;
    bit saw_ds = 1'b0;
    bit fast = is_special(f, a, b) || cache_hit(f, a, b);
    logic [31:0] exp = ref_res(f, a, b);
    bus.ex_valid = 1'b1;
    bus.ex_funct3 = f;
    bus.ex_rs1 = a;
    bus.ex_rs2 = b;
    bus.wb_stall = hold > 0;
    @(negedge clk);
    chk("accept_stall", bus.ex_stall, 1);
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    bus.ex_rs1 = $urandom;
    bus.ex_rs2 = $urandom;
    @(negedge clk);
    while (!bus.mdu_done && cyc < 200) begin
      stall_ok &= bus.ex_stall;
      saw_ds |= bus.div_stall;
      @(negedge clk);
      cyc++;
    end
    chk("done", bus.mdu_done, 1);
    chk("result", bus.mdu_result, exp);
    chk("div_starts", n_valid - v0, fast ? 0 : 1);
    if (fast) chk("fast_latency", cyc, 1);
    else begin
      chk("slow_latency_le40", cyc <= 40, 1);
      chk("stall_until_done", stall_ok, 1);
      if (hold > 0) chk("div_stall_in_wait", saw_ds, 1);
    end
    for (int k = 0; k < hold; k++) begin
      chk("hold_done", bus.mdu_done, 1);
      chk("hold_result", bus.mdu_result, exp);
      chk("hold_ex_stall", bus.ex_stall, 1);
      @(posedge clk);
      #1;
      if (k == hold - 1) bus.wb_stall = 1'b0;
      @(negedge clk);
    end
    chk("release_ex_stall", bus.ex_stall, 0);
    if (!fast) begin
      c_valid = 1'b1;
      c_f = f;
      c_a = a;
      c_b = b;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain_test(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc = 0;
    bit saw_done = 1'b0;
    bit ds = 1'b0;
    force_lat = 15;
    bus.ex_valid = 1'b1;
    bus.ex_funct3 = f;
    bus.ex_rs1 = a;
    bus.ex_rs2 = b;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.wb_stall = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    while (bus.ex_stall && cyc < 100) begin
      saw_done |= bus.mdu_done;
      ds |= bus.div_stall;
      @(negedge clk);
      cyc++;
    end
    chk("drain_exit", bus.ex_stall, 0);
    chk("drain_no_done", saw_done | bus.mdu_done, 0);
    chk("drain_div_stall", ds, 0);
    chk("drain_waits_ready", cyc >= 8, 1);
    bus.wb_stall = 1'b0;
    force_lat = 0;
    c_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin : main
    int cyc;
    bit saw_done;
    logic [2:0] f;
    logic [31:0] a, b;
    bus.flush = 1'b0;
    bus.ex_valid = 1'b0;
    bus.ex_funct3 = '0;
    bus.ex_rs1 = '0;
    bus.ex_rs2 = '0;
    bus.wb_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ex_stall", bus.ex_stall, 0);
    chk("rst_mdu_done", bus.mdu_done, 0);
    chk("rst_div_valid", bus.div_valid, 0);
    chk("rst_div_err", bus.div_err, 0);
    chk("rst_mdu_result", bus.mdu_result, 0);
    chk("rst_div_op1", bus.div_op1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ex_valid = 1'b1;
    bus.ex_funct3 = 3'd1;
    bus.ex_rs1 = 32'd100;
    bus.ex_rs2 = 32'd7;
    @(negedge clk);
    chk("mul_ignored_stall", bus.ex_stall, 0);
    @(posedge clk);
    #1;
    bus.ex_funct3 = 3'd5;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("mul_ignored_valid", bus.div_valid | bus.mdu_done, 0);
    chk("flush_idle_stall", bus.ex_stall, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_nothing", bus.div_valid | bus.mdu_done, 0);
    @(posedge clk);
    #1;
    run_op(3'd5, 32'd100, 32'd7, 0);
    run_op(3'd6, -32'sd7, 32'd2, 0);
    run_op(3'd4, -32'sd7, 32'd2, 0);
    run_op(3'd4, 32'd1234, 32'd0, 0);
    run_op(3'd7, 32'd9, 32'd0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 3);
    run_op(3'd5, 32'd100, 32'd7, 0);
    drain_test(3'd5, 32'd100, 32'd7);
    run_op(3'd5, 32'd100, 32'd7, 0);
    bus.ex_valid = 1'b1;
    bus.ex_funct3 = 3'd4;
    bus.ex_rs1 = 32'd5;
    bus.ex_rs2 = 32'd0;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_done_no_done", bus.mdu_done, 0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_done_idle", bus.ex_stall, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) begin
      f = 3'(4 + $urandom_range(0, 3));
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: if (c_valid) begin f = c_f; a = c_a; b = c_b; end
        default: ;
      endcase
      run_op(f, a, b, $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0);
    end
    mute = 1'b1;
    bus.ex_valid = 1'b1;
    bus.ex_funct3 = 3'd5;
    bus.ex_rs1 = 32'd1000;
    bus.ex_rs2 = 32'd3;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    cyc = 0;
    saw_done = 1'b0;
    while (bus.ex_stall && cyc < 200) begin
      saw_done |= bus.mdu_done;
      @(negedge clk);
      cyc++;
    end
    chk("wdog_err", bus.div_err, 1);
    chk("wdog_len", cyc >= 48 && cyc <= 50, 1);
    chk("wdog_no_done", saw_done, 0);
    c_valid = 1'b0;
    mute = 1'b0;
    @(posedge clk);
    #1;
    run_op(3'd5, 32'd1000, 32'd3, 0);
    chk("wdog_sticky", bus.div_err, 1);
    force_lat = 20;
    bus.ex_valid = 1'b1;
    bus.ex_funct3 = 3'd4;
    bus.ex_rs1 = 32'd77;
    bus.ex_rs2 = 32'd5;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_stall", bus.ex_stall, 0);
    chk("async_rst_err", bus.div_err, 0);
    chk("async_rst_op1", bus.div_op1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    force_lat = 0;
    c_valid = 1'b0;
    run_op(3'd4, 32'd77, 32'd5, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
